// File: rtl/data_memory.sv
// Single-port word-addressed data memory for the memory stage: one-cycle registered
// reads, writes without response, and a sticky access-error flag with captured address.
module data_memory #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] ERR_DATA   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        data_mem_en,
   input  logic        data_mem_wr,
   input  logic [31:0] data_mem_addr,
   input  logic [31:0] data_mem_write_data,
   input  logic        err_clr,
   output logic [31:0] data_mem_data,
   output logic        data_mem_rvalid,
   output logic        data_mem_err,
   output logic [31:0] err_addr
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   // Misaligned or beyond the last implemented word.
   function automatic logic access_error(input logic [31:0] addr);
      return (addr[1:0] != 2'b00) || ((addr >> (DEPTH_LOG2 + 2)) != 32'd0);
   endfunction

   logic [31:0]           mem_r [0:DEPTH-1];
   logic [31:0]           rd_data_r;
   logic                  rvalid_r;
   logic                  err_r;
   logic [31:0]           err_addr_r;

   logic [DEPTH_LOG2-1:0] idx_s;
   logic                  acc_err_s;
   logic                  wr_en_s;
   logic                  rd_en_s;
   logic [31:0]           rd_word_s;
   logic                  err_nxt_s;
   logic [31:0]           err_addr_nxt_s;

   // Request decode, read mux and sticky-error next state.
   always_comb begin
      idx_s          = data_mem_addr[DEPTH_LOG2+1:2];
      acc_err_s      = data_mem_en && access_error(data_mem_addr);
      wr_en_s        = rst_n && data_mem_en && data_mem_wr && !acc_err_s;
      rd_en_s        = data_mem_en && !data_mem_wr;
      rd_word_s      = acc_err_s ? ERR_DATA : mem_r[idx_s];
      err_nxt_s      = err_r;
      err_addr_nxt_s = err_addr_r;
      // A new error beats a simultaneous clear and re-captures its address.
      if (acc_err_s && (!err_r || err_clr)) begin
         err_nxt_s      = 1'b1;
         err_addr_nxt_s = data_mem_addr;
      end else if (!acc_err_s && err_clr) begin
         err_nxt_s      = 1'b0;
         err_addr_nxt_s = 32'd0;
      end else begin
         err_nxt_s      = err_r;
         err_addr_nxt_s = err_addr_r;
      end
   end

   // Storage array; deliberately not reset, writes blocked while in reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[idx_s] <= data_mem_write_data;
      end
   end

   // Registered read data and the one-cycle valid pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_r <= 32'd0;
         rvalid_r  <= 1'b0;
      end else if (rd_en_s) begin
         rd_data_r <= rd_word_s;
         rvalid_r  <= 1'b1;
      end else begin
         rvalid_r  <= 1'b0;
      end
   end

   // Sticky error flag and first-error address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r      <= 1'b0;
         err_addr_r <= 32'd0;
      end else begin
         err_r      <= err_nxt_s;
         err_addr_r <= err_addr_nxt_s;
      end
   end

   assign data_mem_data   = rd_data_r;
   assign data_mem_rvalid = rvalid_r;
   assign data_mem_err    = err_r;
   assign err_addr        = err_addr_r;

endmodule

// File: tb/tb_data_memory.sv
// Directed, table-driven bench for data_memory plus a hand-written reset sequence.
module tb_data_memory;

   localparam logic [31:0] ERR_D = 32'hDEAD_0BAD;

   logic        clk;
   logic        rst_n;
   logic        data_mem_en;
   logic        data_mem_wr;
   logic [31:0] data_mem_addr;
   logic [31:0] data_mem_write_data;
   logic        err_clr;
   logic [31:0] data_mem_data;
   logic        data_mem_rvalid;
   logic        data_mem_err;
   logic [31:0] err_addr;

   int tests;
   int fails;

   typedef struct {
      logic        en;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        clr;
      logic [31:0] exp_data;
      logic        exp_rvalid;
      logic        exp_err;
      logic [31:0] exp_ea;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   data_memory #(.DEPTH_LOG2(10), .ERR_DATA(ERR_D)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .data_mem_en         (data_mem_en),
      .data_mem_wr         (data_mem_wr),
      .data_mem_addr       (data_mem_addr),
      .data_mem_write_data (data_mem_write_data),
      .err_clr             (err_clr),
      .data_mem_data       (data_mem_data),
      .data_mem_rvalid     (data_mem_rvalid),
      .data_mem_err        (data_mem_err),
      .err_addr            (err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [31:0] d, input logic rv,
                            input logic e, input logic [31:0] ea);
      check({tag, " data"}, data_mem_data, d);
      check({tag, " rvalid"}, {31'd0, data_mem_rvalid}, {31'd0, rv});
      check({tag, " err"}, {31'd0, data_mem_err}, {31'd0, e});
      check({tag, " err_addr"}, err_addr, ea);
   endtask

   task automatic drive(input logic en, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic clr);
      @(negedge clk);
      data_mem_en         = en;
      data_mem_wr         = wr;
      data_mem_addr       = addr;
      data_mem_write_data = wd;
      err_clr             = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      //          en    wr    addr          wdata         clr   exp_data      rv    err   err_addr
      vecs[0]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0};
      vecs[3]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0};
      vecs[4]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h1,         1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0};
      vecs[5]  = '{1'b1, 1'b1, 32'h0000_0004, 32'h2,         1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0};
      vecs[6]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h3,         1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1,         1'b1, 1'b0, 32'h0};
      vecs[8]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h2,         1'b1, 1'b0, 32'h0};
      vecs[9]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h3,         1'b1, 1'b0, 32'h0};
      vecs[10] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h3,         1'b0, 1'b0, 32'h0};
      vecs[11] = '{1'b1, 1'b1, 32'h0000_0002, 32'hDEAD_BEEF, 1'b0, 32'h3,         1'b0, 1'b1, 32'h2};
      vecs[12] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1,         1'b1, 1'b1, 32'h2};
      vecs[13] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         1'b0, ERR_D,         1'b1, 1'b1, 32'h2};
      vecs[14] = '{1'b0, 1'b1, 32'h0000_0003, 32'h7777_7777, 1'b0, ERR_D,         1'b0, 1'b1, 32'h2};
      vecs[15] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b1, ERR_D,         1'b0, 1'b0, 32'h0};
      vecs[16] = '{1'b1, 1'b0, 32'h0000_0FFD, 32'h0,         1'b1, ERR_D,         1'b1, 1'b1, 32'hFFD};
      vecs[17] = '{1'b1, 1'b1, 32'h0000_0FFC, 32'h1234_5678, 1'b0, ERR_D,         1'b0, 1'b1, 32'hFFD};
      vecs[18] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'h1234_5678, 1'b1, 1'b1, 32'hFFD};
      vecs[19] = '{1'b1, 1'b1, 32'h0000_2001, 32'hAAAA_5555, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 32'hFFD};
      vecs[20] = '{1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 32'hFFD};
      vecs[21] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1,         1'b1, 1'b1, 32'hFFD};

      rst_n               = 1'b0;
      data_mem_en         = 1'b0;
      data_mem_wr         = 1'b0;
      data_mem_addr       = 32'h0;
      data_mem_write_data = 32'h0;
      err_clr             = 1'b0;
      #1;
      check_all("reset", 32'h0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].clr);
         check_all($sformatf("v%0d", i), vecs[i].exp_data, vecs[i].exp_rvalid,
                   vecs[i].exp_err, vecs[i].exp_ea);
      end

      // Reset in the middle of a read response; writes presented during reset must be dropped.
      drive(1'b1, 1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 1'b0);
      check_all("pre_wr", 32'h1, 1'b0, 1'b1, 32'hFFD);
      drive(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
      check_all("pre_rd", 32'hCAFE_F00D, 1'b1, 1'b1, 32'hFFD);
      #2;
      rst_n               = 1'b0;
      data_mem_wr         = 1'b1;
      data_mem_addr       = 32'h0000_03FC;
      data_mem_write_data = 32'h1111_1111;
      #1;
      check_all("rst_async", 32'h0, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      check_all("rst_hold", 32'h0, 1'b0, 1'b0, 32'h0);
      rst_n       = 1'b1;
      data_mem_en = 1'b1;
      data_mem_wr = 1'b0;
      #1;
      check_all("rel", 32'h0, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      check_all("rel_rd", 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0);
      drive(1'b1, 1'b1, 32'h0000_03FC, 32'h5A5A_A5A5, 1'b0);
      check_all("post_wr", 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0000_03FC, 32'h0, 1'b0);
      check_all("post_rd", 32'h5A5A_A5A5, 1'b1, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      check_all("post_idle", 32'h5A5A_A5A5, 1'b0, 1'b0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of the number of 32-bit words (1024 words).
REQ-002 SHALL have parameter ERR_DATA, default 32'h0000_0000, the read data returned for an errored read.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port data_mem_en  input  1  access request from the memory stage.
REQ-006 SHALL have port data_mem_wr  input  1  1 = write, 0 = read; qualified by data_mem_en.
REQ-007 SHALL have port data_mem_addr  input  32  byte address.
REQ-008 SHALL have port data_mem_write_data  input  32  store data.
REQ-009 SHALL have port err_clr  input  1  clears the sticky error.
REQ-010 SHALL have port data_mem_data  output  32  registered read data.
REQ-011 SHALL have port data_mem_rvalid  output  1  one-cycle pulse marking new read data.
REQ-012 SHALL have port data_mem_err  output  1  sticky access-error flag.
REQ-013 SHALL have port err_addr  output  32  byte address of the first errored access.

Function
REQ-014 SHALL decode word index = data_mem_addr[DEPTH_LOG2+1:2].
REQ-015 SHALL treat an access as errored when data_mem_addr[1:0] != 0 (misaligned) or data_mem_addr[31:DEPTH_LOG2+2] != 0 (out of range).
REQ-016 SHALL, on an edge with en=1, wr=1 and no error, write data_mem_write_data to the indexed word; no rvalid pulse.
REQ-017 SHALL suppress the array write for an errored write; memory contents unchanged.
REQ-018 SHALL, on an edge with en=1, wr=0, load the indexed word (or ERR_DATA if errored) into data_mem_data and assert data_mem_rvalid for exactly the following cycle (latency 1), matching the memory stage's one-cycle read stall.
REQ-019 SHALL hold data_mem_data stable until the next accepted read; writes and idle cycles do not alter it.
REQ-020 SHALL accept a new read every cycle (fully pipelined); consecutive reads produce consecutive rvalid pulses.
REQ-021 SHALL return the newly written value for a read in the cycle after a write to the same word; same-edge read/write impossible (single port).
REQ-022 SHALL ignore data_mem_wr, addr and write_data when data_mem_en=0.
REQ-023 SHALL set data_mem_err and capture err_addr on the first errored access while data_mem_err=0; later errors do not overwrite err_addr.
REQ-024 SHALL clear data_mem_err and err_addr to 0 on the edge where err_clr=1 and no errored access is presented.
REQ-025 SHALL, when err_clr=1 coincides with an errored access, leave data_mem_err=1 and capture the new address (error wins).
REQ-026 SHALL not initialise or reset the memory array; contents undefined until written.

Reset
REQ-027 SHALL, while rst_n=0, force data_mem_data=0, data_mem_rvalid=0, data_mem_err=0, err_addr=0, independent of clk.
REQ-028 SHALL discard a read accepted in the edge before rst_n falls: no rvalid after reset release.
REQ-029 SHALL ignore requests while rst_n=0; array writes blocked during reset.
REQ-030 SHALL resume accepting requests on the first rising edge after rst_n rises.

Verification
REQ-031 Write 0x0000_0010 <- 0xCAFE_F00D, then read 0x10 -> next cycle data_mem_data=0xCAFE_F00D, rvalid=1 for one cycle, then rvalid=0 with data held.
REQ-032 Back-to-back reads of 0x0, 0x4, 0x8 (preloaded 1, 2, 3) -> three consecutive rvalid cycles with data 1, 2, 3.
REQ-033 Write to 0x0000_0002 (misaligned) -> err=1, err_addr=0x2, word 0 unchanged; later read of 0x0000_1000 (out of range, DEPTH_LOG2=10) -> data=ERR_DATA, rvalid=1, err_addr still 0x2.
REQ-034 err_clr=1 alone -> err=0, err_addr=0; err_clr=1 with read of 0x0000_0FFD -> err=1, err_addr=0xFFD.
REQ-035 Read issued then rst_n low mid-cycle -> outputs 0 immediately, no rvalid after release; post-release write/read of 0x3FC returns written value.
